// File: rtl/ib.sv
// ib: per-input-port packet FIFO with one-hot request toward the crossbar.
// Optional drop counter enabled by defining IB_DROPCNT_EN.
`ifndef PKTW
`define PKTW 9
`endif
`ifndef PORT
`define PORT 3
`endif
`ifndef ASSERT
`define ASSERT 1'b1
`endif

module ib #(
  parameter int DEPTH = 4,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [`PKTW:0]  i,
  input  logic [`PORT:0]  ack,
  output logic [`PKTW:0]  co,
  output logic [`PORT:0]  req,
  output logic            full
`ifdef IB_DROPCNT_EN
  ,
  output logic [7:0]      drop
`endif
);

  logic [`PKTW:0] mem [DEPTH];
  logic [PTRW-1:0] rp;
  logic [PTRW-1:0] wp;
  logic [PTRW:0]   cnt;
  logic [`PORT:0]  acka;
  logic [1:0]      dst;
  logic            nempty;
  logic            push;
  logic            pop;

  // normalise ack polarity to active-high
  assign acka   = ack ^ {(`PORT+1){~`ASSERT}};
  assign nempty = (cnt != '0);
  assign co     = nempty ? mem[rp] : '0;
  assign dst    = co[`PKTW:`PKTW-1];
  assign full   = (cnt == (PTRW+1)'(DEPTH));
  assign pop    = nempty && ((acka & req) != '0);
  assign push   = (i != '0) && (!full || pop);

  always_comb begin
    req = '0;
    if (nempty) begin
      unique case (dst)
        2'd0: req = 4'b0001;
        2'd1: req = 4'b0010;
        2'd2: req = 4'b0100;
        2'd3: req = 4'b1000;
        default: req = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wp] <= i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef IB_DROPCNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      drop <= '0;
    else if ((i != '0) && full && !pop && (drop != 8'hFF))
      drop <= drop + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ib.sv
// tb_ib: directed vector table plus randomized run against a queue model.
// Drop checks are active when IB_DROPCNT_EN is defined.
`timescale 1ns/1ps
module tb_ib;

  logic       clk;
  logic       rst;
  logic [9:0] i;
  logic [3:0] ack;
  logic [9:0] co;
  logic [3:0] req;
  logic       full;
  logic [7:0] drop;

  int passed;
  int total;

  logic [9:0] q[$];
  int mdrop;

  typedef struct {
    logic       r;
    logic [9:0] ii;
    logic [3:0] aa;
    logic [9:0] eco;
    logic [3:0] ereq;
    logic       efull;
    int         edrop;
  } vec_t;

  vec_t tab[20];

  ib #(.DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .i(i),
    .ack(ack),
    .co(co),
    .req(req),
    .full(full)
`ifdef IB_DROPCNT_EN
    ,
    .drop(drop)
`endif
  );

`ifndef IB_DROPCNT_EN
  assign drop = 8'h00;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input logic [9:0] p);
    logic [3:0] r;
    r = 4'b0001 << p[9:8];
    return r;
  endfunction

  function automatic logic [3:0] mreq();
    if (q.size() == 0)
      return 4'b0000;
    return oh(q[0]);
  endfunction

  function automatic logic [9:0] mco();
    if (q.size() == 0)
      return 10'h000;
    return q[0];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp)
      passed++;
    else
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic model(input logic r, input logic [9:0] ii,
                       input logic [3:0] aa);
    bit pp;
    bit ps;
    if (r) begin
      q.delete();
      mdrop = 0;
    end else begin
      pp = (q.size() != 0) && ((aa & mreq()) != 0);
      ps = (ii != 0) && ((q.size() < 4) || pp);
      if (ii != 0 && q.size() == 4 && !pp && mdrop < 255)
        mdrop++;
      if (pp)
        void'(q.pop_front());
      if (ps)
        q.push_back(ii);
    end
  endtask

  task automatic step(input logic r, input logic [9:0] ii,
                      input logic [3:0] aa);
    rst = r;
    i   = ii;
    ack = aa;
    model(r, ii, aa);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(input logic r, input logic [9:0] ii,
                             input logic [3:0] aa, input logic [9:0] c,
                             input logic [3:0] rq, input logic f,
                             input int d);
    vec_t x;
    x.r = r; x.ii = ii; x.aa = aa;
    x.eco = c; x.ereq = rq; x.efull = f; x.edrop = d;
    return x;
  endfunction

  initial begin
    logic [9:0] pk[10];
    logic [3:0] a;
    logic [9:0] ri;
    passed = 0;
    total  = 0;
    mdrop  = 0;
    rst = 1'b1;
    i   = '0;
    ack = '0;

    tab[0]  = v(1, 10'h255, 4'h0, 10'h000, 4'b0000, 0, 0);
    tab[1]  = v(1, 10'h255, 4'h0, 10'h000, 4'b0000, 0, 0);
    tab[2]  = v(0, 10'h203, 4'h0, 10'h203, 4'b0100, 0, 0);
    tab[3]  = v(0, 10'h000, 4'h0, 10'h203, 4'b0100, 0, 0);
    tab[4]  = v(0, 10'h000, 4'h0, 10'h203, 4'b0100, 0, 0);
    tab[5]  = v(0, 10'h000, 4'h0, 10'h203, 4'b0100, 0, 0);
    tab[6]  = v(0, 10'h000, 4'h4, 10'h000, 4'b0000, 0, 0);
    tab[7]  = v(0, 10'h1AB, 4'h0, 10'h1AB, 4'b0010, 0, 0);
    tab[8]  = v(0, 10'h000, 4'h1, 10'h1AB, 4'b0010, 0, 0);
    tab[9]  = v(0, 10'h000, 4'h2, 10'h000, 4'b0000, 0, 0);
    tab[10] = v(0, 10'h101, 4'h0, 10'h101, 4'b0010, 0, 0);
    tab[11] = v(0, 10'h102, 4'h0, 10'h101, 4'b0010, 0, 0);
    tab[12] = v(0, 10'h103, 4'h0, 10'h101, 4'b0010, 0, 0);
    tab[13] = v(0, 10'h104, 4'h0, 10'h101, 4'b0010, 1, 0);
    tab[14] = v(0, 10'h105, 4'h0, 10'h101, 4'b0010, 1, 1);
    tab[15] = v(0, 10'h3AA, 4'h2, 10'h102, 4'b0010, 1, 1);
    tab[16] = v(0, 10'h000, 4'h2, 10'h103, 4'b0010, 0, 1);
    tab[17] = v(0, 10'h000, 4'h2, 10'h104, 4'b0010, 0, 1);
    tab[18] = v(0, 10'h000, 4'h2, 10'h3AA, 4'b1000, 0, 1);
    tab[19] = v(0, 10'h000, 4'h8, 10'h000, 4'b0000, 0, 1);

    for (int k = 0; k < 20; k++) begin
      step(tab[k].r, tab[k].ii, tab[k].aa);
      chk($sformatf("vec%0d co", k), co, tab[k].eco);
      chk($sformatf("vec%0d req", k), req, tab[k].ereq);
      chk($sformatf("vec%0d full", k), full, tab[k].efull);
`ifdef IB_DROPCNT_EN
      chk($sformatf("vec%0d drop", k), drop, tab[k].edrop);
`endif
    end

    // streaming across pointer wrap, ack tracks previous packet
    for (int k = 0; k < 10; k++)
      pk[k] = {k[1:0], 8'h10 + k[7:0]};
    for (int k = 0; k < 10; k++) begin
      a = (k == 0) ? 4'b0000 : oh(pk[k-1]);
      step(0, pk[k], a);
      chk($sformatf("stream%0d co", k), co, pk[k]);
      chk($sformatf("stream%0d req", k), req, oh(pk[k]));
    end
    step(1, 10'h2C1, 4'b0000);
    chk("midrst co", co, 0);
    chk("midrst req", req, 0);
    chk("midrst full", full, 0);

    // randomized run against the queue model
    for (int k = 0; k < 3000; k++) begin
      ri = ($urandom_range(0, 2) == 0) ? 10'h000 : 10'($urandom);
      if ($urandom_range(0, 1) == 0)
        a = mreq() | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      else
        a = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0)
        a = 4'b0000;
      step(($urandom_range(0, 299) == 0), ri, a);
      chk("rnd co", co, mco());
      chk("rnd req", req, mreq());
      chk("rnd full", full, (q.size() == 4));
`ifdef IB_DROPCNT_EN
      chk("rnd drop", drop, mdrop);
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
